cv32e40p_tb_obi_mem: RTL

- Parametrised multi-port OBI memory model for the cv32e40p testbench subsystem.
- Serves NUM_PORTS independent OBI requestors (e.g. instruction, data, debug/DMA) from one shared single-ported word RAM.
- Round-robin arbitration, a fixed response latency, and optional periodic grant stalls to stress core handshakes.
- Memory-mapped exit register drives the test pass/fail/exit outputs.

---
 rtl/cv32e40p_tb_obi_mem.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_tb_obi_mem.sv
// cv32e40p_tb_obi_mem: multi-port OBI memory model for the cv32e40p testbench.
// Round-robin arbitration onto one shared word RAM with fixed-latency responses.
module cv32e40p_tb_obi_mem #(
    parameter int          NUM_PORTS      = 2,
    parameter int          RAM_ADDR_WIDTH = 20,
    parameter int          RESP_LATENCY   = 1,
    parameter int          STALL_PERIOD   = 0,
    parameter logic [31:0] EXIT_ADDR      = 32'h2000_0004
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_PORTS-1:0]      req_i,
    input  logic [NUM_PORTS*32-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]      we_i,
    input  logic [NUM_PORTS*4-1:0]    be_i,
    input  logic [NUM_PORTS*32-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]      gnt_o,
    output logic [NUM_PORTS-1:0]      rvalid_o,
    output logic [NUM_PORTS*32-1:0]   rdata_o,
    output logic                      exit_valid_o,
    output logic [31:0]               exit_value_o,
    output logic                      tests_passed_o,
    output logic                      tests_failed_o,
    output logic                      err_o
);

    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WW    = RAM_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WW;

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        sel;
    logic                 any;
    logic                 stall;
    logic                 gnt_ok;
    logic [NUM_PORTS-1:0] gnt;
    int                   arb_idx;

    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_be;
    logic                 sel_we;
    logic                 hit_exit;
    logic                 hit_ram;
    logic                 hit_err;
    logic [WW-1:0]        widx;
    logic [31:0]          resp_data;

    logic [31:0]          mem [DEPTH];
    logic                 exit_valid;
    logic [31:0]          exit_value;
    logic                 err;

    logic [RESP_LATENCY-1:0] pv [NUM_PORTS];
    logic [31:0]             pd [NUM_PORTS][RESP_LATENCY];

    generate
        if (STALL_PERIOD >= 2) begin : g_stall
            localparam int CW = $clog2(STALL_PERIOD);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt <= '0;
                end else if (cnt == CW'(STALL_PERIOD - 1)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign stall = (cnt == CW'(STALL_PERIOD - 1));
        end else begin : g_nostall
            assign stall = 1'b0;
        end
    endgenerate

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        any     = 1'b0;
        sel     = '0;
        arb_idx = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            arb_idx = (int'(ptr) + i) % NUM_PORTS;
            if (!any && req_i[arb_idx]) begin
                any = 1'b1;
                sel = PW'(arb_idx);
            end
        end
    end

    assign gnt_ok = any && !stall && !rst_i;

    always_comb begin
        gnt = '0;
        if (gnt_ok) begin
            gnt[sel] = 1'b1;
        end
    end

    assign gnt_o = gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (gnt_ok) begin
            ptr <= (int'(sel) == NUM_PORTS - 1) ? '0 : sel + PW'(1);
        end
    end

    assign sel_addr  = addr_i[32*sel +: 32];
    assign sel_wdata = wdata_i[32*sel +: 32];
    assign sel_be    = be_i[4*sel +: 4];
    assign sel_we    = we_i[sel];

    assign hit_exit = (sel_addr == EXIT_ADDR);
    assign hit_ram  = !hit_exit && ((sel_addr >> RAM_ADDR_WIDTH) == 32'd0);
    assign hit_err  = !hit_exit && !hit_ram;
    assign widx     = WW'(sel_addr >> 2);

    always_comb begin
        resp_data = '0;
        if (!sel_we) begin
            unique case (1'b1)
                hit_exit: resp_data = exit_value;
                hit_ram:  resp_data = mem[widx];
                default:  resp_data = 32'hDEAD_BEEF;
            endcase
        end
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (gnt_ok && sel_we && hit_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_be[b]) begin
                    mem[widx][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exit_valid <= 1'b0;
            exit_value <= '0;
            err        <= 1'b0;
        end else if (gnt_ok) begin
            if (hit_exit && sel_we && !exit_valid) begin
                exit_valid <= 1'b1;
                exit_value <= sel_wdata;
            end
            if (hit_err) begin
                err <= 1'b1;
            end
        end
    end

    // Data in each stage only moves with a valid, so the last stage holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pv[p] <= '0;
                for (int s = 0; s < RESP_LATENCY; s++) begin
                    pd[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pv[p][0] <= gnt[p];
                if (gnt[p]) begin
                    pd[p][0] <= resp_data;
                end
                for (int s = 1; s < RESP_LATENCY; s++) begin
                    pv[p][s] <= pv[p][s-1];
                    if (pv[p][s-1]) begin
                        pd[p][s] <= pd[p][s-1];
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
            assign rvalid_o[p]         = pv[p][RESP_LATENCY-1];
            assign rdata_o[32*p +: 32] = pd[p][RESP_LATENCY-1];
        end
    endgenerate

    assign exit_valid_o   = exit_valid;
    assign exit_value_o   = exit_value;
    assign tests_passed_o = exit_valid && (exit_value == 32'd0);
    assign tests_failed_o = exit_valid && (exit_value != 32'd0);
    assign err_o          = err;

endmodule
